// File: rtl/xor_checksum_unit_if.sv
// Stream bundle for xor_checksum_unit: word input stream and per-frame result stream.
// master drives words and accepts results; slave is the checksum unit.
interface xor_checksum_unit_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             odd_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_parity;
    logic [CNT_W-1:0] out_count;
    logic             out_err;

    modport master (
        output in_valid, in_data, in_last, odd_mode, out_ready,
        input  in_ready, out_valid, out_sum, out_parity, out_count, out_err
    );

    modport slave (
        input  in_valid, in_data, in_last, odd_mode, out_ready,
        output in_ready, out_valid, out_sum, out_parity, out_count, out_err
    );
endinterface

// File: rtl/xor_checksum_unit.sv
// Streaming XOR checksum/parity engine: folds each frame's words into one XOR word and
// reports it with parity, word count and an overflow flag on a valid/ready result stream.
//
// state | meaning
// IDLE  | waiting for the first word of a frame
// ACCUM | frame open, folding words until in_last or MAX_WORDS
// DONE  | result presented, input stalled until the result is taken
module xor_checksum_unit #(
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 16,
    parameter int CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    xor_checksum_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             mode_q, mode_d;
    logic             load, err_d;
    logic             beat;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_sum_q;
    logic             out_parity_q;
    logic [CNT_W-1:0] out_count_q;
    logic             out_err_q;

    assign bus.in_ready = (state_q != DONE) && !rst;
    assign beat         = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        mode_d  = mode_q;
        load    = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (beat) begin
                    acc_d   = bus.in_data;
                    count_d = CNT_W'(1);
                    mode_d  = bus.odd_mode;
                    if (bus.in_last || MAX_WORDS == 1) begin
                        state_d = DONE;
                        load    = 1'b1;
                        err_d   = !bus.in_last;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (beat) begin
                    acc_d   = acc_q ^ bus.in_data;
                    count_d = count_q + CNT_W'(1);
                    if (bus.in_last) begin
                        state_d = DONE;
                        load    = 1'b1;
                    end else if (count_d == CNT_W'(MAX_WORDS)) begin
                        // Forced close: the rest of the source frame starts a new frame.
                        state_d = DONE;
                        load    = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            DONE: begin
                if (out_valid_q && bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            count_q      <= '0;
            mode_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_sum_q    <= '0;
            out_parity_q <= 1'b0;
            out_count_q  <= '0;
            out_err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            if (load) begin
                out_valid_q  <= 1'b1;
                out_sum_q    <= acc_d;
                out_parity_q <= (^acc_d) ^ mode_d;
                out_count_q  <= count_d;
                out_err_q    <= err_d;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_sum    = out_sum_q;
    assign bus.out_parity = out_parity_q;
    assign bus.out_count  = out_count_q;
    assign bus.out_err    = out_err_q;
endmodule

// File: tb/tb_xor_checksum_unit.sv
// Directed bench for xor_checksum_unit (WIDTH=8, MAX_WORDS=4) with hand-computed results.
module tb_xor_checksum_unit;
    localparam int WIDTH     = 8;
    localparam int MAX_WORDS = 4;
    localparam int CNT_W     = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    xor_checksum_unit_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) ifc ();

    xor_checksum_unit #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word and hold it until the unit accepts it.
    task automatic send_word(input logic [7:0] data, input logic last, input logic mode);
        int budget;
        ifc.in_valid = 1'b1;
        ifc.in_data  = data;
        ifc.in_last  = last;
        ifc.odd_mode = mode;
        budget = 50;
        while (!ifc.in_ready && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) chk("send_timeout", ifc.in_ready, 1);
        tick();
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [7:0] sum, input logic par,
                                input logic [2:0] cnt, input logic err);
        int budget;
        budget = 50;
        while (!ifc.out_valid && budget > 0) begin
            tick();
            budget--;
        end
        chk({tag, "_valid"}, ifc.out_valid, 1);
        chk({tag, "_sum"}, ifc.out_sum, sum);
        chk({tag, "_parity"}, ifc.out_parity, par);
        chk({tag, "_count"}, ifc.out_count, cnt);
        chk({tag, "_err"}, ifc.out_err, err);
        chk({tag, "_inready_stall"}, ifc.in_ready, 0);
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
        chk({tag, "_valid_drop"}, ifc.out_valid, 0);
        chk({tag, "_inready_back"}, ifc.in_ready, 1);
    endtask

    initial begin
        logic [7:0] frame3 [3];
        int         gaps   [3];
        frame3[0] = 8'hA5; frame3[1] = 8'h3C; frame3[2] = 8'hFF;
        gaps[0] = 2; gaps[1] = 0; gaps[2] = 3;

        ifc.in_valid  = 1'b0;
        ifc.in_data   = '0;
        ifc.in_last   = 1'b0;
        ifc.odd_mode  = 1'b0;
        ifc.out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_inready", ifc.in_ready, 0);
        chk("rst_valid", ifc.out_valid, 0);
        chk("rst_sum", ifc.out_sum, 0);
        chk("rst_parity", ifc.out_parity, 0);
        chk("rst_count", ifc.out_count, 0);
        chk("rst_err", ifc.out_err, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_inready", ifc.in_ready, 1);

        // Single word, result must appear right after acceptance
        send_word(8'h01, 1'b1, 1'b0);
        chk("single_latency", ifc.out_valid, 1);
        check_result("single", 8'h01, 1'b1, 3'd1, 1'b0);

        // Three-word frame, even then odd (odd only on first beat)
        for (int i = 0; i < 3; i++) send_word(frame3[i], i == 2, 1'b0);
        check_result("even3", 8'h66, 1'b0, 3'd3, 1'b0);
        for (int i = 0; i < 3; i++) send_word(frame3[i], i == 2, i == 0);
        check_result("odd3", 8'h66, 1'b1, 3'd3, 1'b0);

        // Overflow at MAX_WORDS, then the trailing word as its own frame
        for (int i = 0; i < 4; i++) send_word(8'(1 << i), 1'b0, 1'b0);
        check_result("ovf", 8'h0F, 1'b0, 3'd4, 1'b1);
        send_word(8'h10, 1'b1, 1'b0);
        check_result("ovf_tail", 8'h10, 1'b1, 3'd1, 1'b0);

        // Last on the MAX_WORDS-th beat is a normal close
        for (int i = 0; i < 4; i++) send_word(8'h11, i == 3, 1'b1);
        check_result("max_last", 8'h00, 1'b1, 3'd4, 1'b0);

        // Backpressure: result and stall hold while out_ready is low
        for (int i = 0; i < 3; i++) send_word(frame3[i], i == 2, 1'b0);
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", ifc.out_valid, 1);
            chk("bp_sum", ifc.out_sum, 8'h66);
            chk("bp_count", ifc.out_count, 3);
            chk("bp_inready", ifc.in_ready, 0);
            tick();
        end
        check_result("bp", 8'h66, 1'b0, 3'd3, 1'b0);

        // Idle gaps inside the frame
        for (int i = 0; i < 3; i++) begin
            for (int g = 0; g < gaps[i]; g++) tick();
            send_word(frame3[i], i == 2, 1'b0);
        end
        check_result("gaps", 8'h66, 1'b0, 3'd3, 1'b0);

        // Reset mid-frame discards the partial frame and clears outputs
        send_word(8'hC3, 1'b0, 1'b0);
        send_word(8'h0F, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        chk("mid_rst_inready", ifc.in_ready, 0);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", ifc.out_valid, 0);
        chk("mid_rst_sum", ifc.out_sum, 0);
        chk("mid_rst_count", ifc.out_count, 0);
        chk("mid_rst_inready_back", ifc.in_ready, 1);
        send_word(8'h5A, 1'b1, 1'b0);
        check_result("after_rst", 8'h5A, 1'b0, 3'd1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/xor_checksum_unit.md
# xor_checksum_unit

Parametrised streaming XOR checksum and parity engine. It generalises the 2-input XOR gate to a WIDTH-bit, multi-word reduction over frames delimited by a last flag. It accepts words on a valid/ready input stream, folds them into a running XOR accumulator, and presents the checksum, a selectable even/odd parity bit, the word count and an overflow error on a valid/ready output stream. It sits between a packet source and a link framer, where it generates or checks per-frame integrity words.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (≥1)
- MAX_WORDS, 16, maximum words per frame (≥1)
- CNT_W, $clog2(MAX_WORDS+1), width of the word counter

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  input word present
- in_ready  output  1  unit can accept a word
- in_data  input  WIDTH  input word
- in_last  input  1  word is the final word of its frame
- odd_mode  input  1  parity mode (0 even, 1 odd); sampled on the first beat of each frame
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- out_sum  output  WIDTH  XOR of all frame words
- out_parity  output  1  parity bit over out_sum per latched mode
- out_count  output  CNT_W  number of words accepted in the frame
- out_err  output  1  frame force-terminated at MAX_WORDS without in_last

## Operation
- A beat is accepted when in_valid && in_ready.
- States are IDLE, ACCUM and DONE. in_ready = (state != DONE) && !rst.
- IDLE, on an accepted beat: acc <= in_data; count <= 1; mode <= odd_mode. If in_last or MAX_WORDS==1, the unit goes to DONE; otherwise it goes to ACCUM.
- ACCUM, on an accepted beat: acc <= acc ^ in_data; count <= count+1.
  - If in_last, go to DONE with err=0.
  - Else if count+1 == MAX_WORDS, go to DONE with err=1.
  - odd_mode is ignored in ACCUM.
- DONE:
  - out_valid=1, and out_sum/out_parity/out_count/out_err are held stable.
  - On out_valid && out_ready, go to IDLE.
  - Input is stalled, with no bypass.
- out_parity = (^acc) ^ mode. In even mode, ones in {sum,parity} are even; in odd mode, they are odd.
- After overflow termination, any remaining words of the source frame are treated as a new frame.
- in_last on the MAX_WORDS-th beat is a normal termination with err=0.
- Output registers change only when entering DONE. They keep their last value in IDLE/ACCUM, but are meaningful only while out_valid=1.
- A beat with in_valid=0 changes no state. Idle gaps inside a frame are allowed.

## Timing
- Reset values:
  - state = IDLE, out_valid=0, out_sum=0, out_parity=0, out_count=0, out_err=0.
  - in_ready=0 while rst is high, and 1 on the first cycle after rst deasserts.
- Reset asserted mid-frame or in DONE discards the accumulator and any pending result. No output handshake completes in the reset cycle.
- Latency: out_valid rises on the cycle after the terminating beat is accepted.
- Throughput: with out_ready held high, a frame of N words occupies N+1 cycles (N input beats plus one DONE cycle). in_ready returns to 1 on the cycle after the output handshake.
- in_ready is a combinational function of state and rst only, never of in_valid. out_valid is registered.
- Backpressure: while out_ready=0 in DONE, all outputs hold and in_ready stays 0 indefinitely.

## Test plan
- Reset then a single word 0x01 with in_last=1, even mode → 1 cycle later: out_valid=1, out_sum=0x01, out_parity=1, out_count=1, out_err=0.
- Frame 0xA5, 0x3C, 0xFF (last on 0xFF), even mode → out_sum=0x66, out_parity=0, out_count=3, out_err=0. Repeat with odd_mode=1 on the first beat → out_parity=1.
- MAX_WORDS=4, words 0x01, 0x02, 0x04, 0x08 with in_last never set → out_sum=0x0F, out_count=4, out_err=1, out_parity=0. A fifth word 0x10 with in_last=1 → a separate result with out_sum=0x10, out_count=1, out_err=0.
- Hold out_ready=0 for 5 cycles after a result appears → out_* stable and in_ready=0 throughout. Raise out_ready → handshake completes and in_ready=1 on the next cycle.
- Random idle gaps (in_valid toggling) within the 3-word frame → identical result to the gapless case.
- Assert rst for 1 cycle after 2 words of a frame → all outputs at reset values. A following frame with single word 0x5A → out_sum=0x5A, out_count=1.
